// File: rtl/data_ram.sv
// data_ram: word-organised data memory answering the MEM-stage data port.
// Each access is captured in IDLE, waits WAIT_STATES cycles, then completes in a one-cycle DONE.
module data_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  input  logic        flush_i,
  output logic [31:0] data_o,
  output logic        stallreq_o
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_r, state_s;
  logic [3:0]              cnt_r, cnt_s;
  logic                    req_we_r;
  logic [ADDR_WIDTH-1:0]   req_idx_r;
  logic [3:0]              req_sel_r;
  logic [31:0]             req_data_r;
  logic [31:0]             data_r;
  logic                    capture_s;
  logic                    access_s;
  logic                    stall_s;
  logic [31:0]             mem_r [0:DEPTH-1];

  // Address bits outside the word index are don't-care: aliasing is intended.
  logic unused_addr_s;
  assign unused_addr_s = ^{addr_i[31:ADDR_WIDTH+2], addr_i[1:0]};

  // Next-state, wait counter and stall request decode
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    access_s  = 1'b0;
    stall_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ce_i && !flush_i) begin
          capture_s = 1'b1;
          stall_s   = 1'b1;
          cnt_s     = CNT_LOAD;
          state_s   = ST_WAIT;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush_i) begin
          cnt_s   = 4'd0;
          state_s = ST_IDLE;
        end else if (cnt_r == 4'd0) begin
          access_s = 1'b1;
          stall_s  = 1'b1;
          state_s  = ST_DONE;
        end else begin
          cnt_s   = cnt_r - 4'd1;
          stall_s = 1'b1;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        cnt_s   = 4'd0;
        state_s = ST_IDLE;
      end
    endcase
  end

  assign stallreq_o = rst ? stall_s : 1'b0;

  // State, counter and request capture registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      req_we_r   <= 1'b0;
      req_idx_r  <= '0;
      req_sel_r  <= 4'd0;
      req_data_r <= 32'h0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (capture_s) begin
        req_we_r   <= we_i;
        req_idx_r  <= addr_i[ADDR_WIDTH+1:2];
        req_sel_r  <= sel_i;
        req_data_r <= data_i;
      end
    end
  end

  // Read data register; writes leave it untouched
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_r <= 32'h0;
    end else if (access_s && !req_we_r) begin
      data_r <= mem_r[req_idx_r];
    end
  end

  assign data_o = data_r;

  // Byte-lane write into the un-reset array
  always_ff @(posedge clk) begin
    if (access_s && req_we_r) begin
      for (int k = 0; k < 4; k++) begin
        if (req_sel_r[k]) begin
          mem_r[req_idx_r][8*k +: 8] <= req_data_r[8*k +: 8];
        end
      end
    end
  end

endmodule
